multicycle_control: RTL and testbench

Multi-cycle sequencer for the LEGv8 decode/execute datapath. It replaces single-cycle combinational control with an FSM that steps each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK. It drives the same control-signal set as the combinational control unit, plus per-state write strobes. It handshakes with instruction and data memory, and it counts retired instructions.

---
 rtl/legv8_pkg.sv | 39 +++
 rtl/multicycle_control_opcode_classifier.sv | 24 ++
 rtl/multicycle_control.sv | 150 +++++++++++++++
 tb/tb_multicycle_control.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/legv8_pkg.sv
// Shared LEGv8 control definitions: opcode constants, ALU-op encoding,
// sequencer states and decoded instruction classes.
package legv8_pkg;

  localparam logic [10:0] OP_ADD  = 11'h458;
  localparam logic [10:0] OP_SUB  = 11'h658;
  localparam logic [10:0] OP_AND  = 11'h450;
  localparam logic [10:0] OP_ORR  = 11'h550;
  localparam logic [10:0] OP_LDUR = 11'h7C2;
  localparam logic [10:0] OP_STUR = 11'h7C0;

  // CBZ matches on opcode[10:3], B on opcode[10:5]
  localparam logic [7:0] CBZ_PREFIX = 8'hB4;
  localparam logic [5:0] B_PREFIX   = 6'h05;

  typedef enum logic [1:0] {
    ALU_ADD    = 2'b00,
    ALU_PASS_B = 2'b01,
    ALU_FUNCT  = 2'b10
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_MEMORY,
    ST_WRITEBACK
  } state_e;

  typedef enum logic [2:0] {
    CLS_INVALID,
    CLS_RTYPE,
    CLS_LOAD,
    CLS_STORE,
    CLS_CBZ,
    CLS_B
  } class_e;

endpackage

// File: rtl/multicycle_control_opcode_classifier.sv
// Purely combinational opcode -> instruction class decode, shared with the
// single-cycle control unit.
module opcode_classifier
  import legv8_pkg::*;
(
  input  logic [10:0] opcode,
  output class_e      cls
);

  always_comb begin
    cls = CLS_INVALID;
    if (opcode == OP_ADD || opcode == OP_SUB || opcode == OP_AND || opcode == OP_ORR)
      cls = CLS_RTYPE;
    else if (opcode == OP_LDUR)
      cls = CLS_LOAD;
    else if (opcode == OP_STUR)
      cls = CLS_STORE;
    else if (opcode[10:3] == CBZ_PREFIX)
      cls = CLS_CBZ;
    else if (opcode[10:5] == B_PREFIX)
      cls = CLS_B;
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle LEGv8 sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK with
// memory handshakes, per-state strobes and a retired-instruction counter.
//
// state        | meaning
// ST_FETCH     | request instruction, load IR when imem_ready
// ST_DECODE    | latch class; invalid opcodes pulse illegal and refetch
// ST_EXECUTE   | ALU step; branches update PC here
// ST_MEMORY    | load/store held until dmem_ready
// ST_WRITEBACK | register write and PC+4
module multicycle_control
  import legv8_pkg::*;
#(
  parameter int OPCODE_WIDTH = 11,
  parameter int COUNT_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    alu_zero,
  input  logic                    imem_ready,
  input  logic                    dmem_ready,
  output logic                    imem_req,
  output logic                    ir_write,
  output logic                    reg2_loc,
  output logic                    uncondbranch,
  output logic                    branch,
  output logic                    mem_read,
  output logic                    mem_to_reg,
  output logic [1:0]              alu_op,
  output logic                    mem_write,
  output logic                    alu_src,
  output logic                    reg_write,
  output logic                    pc_write,
  output logic                    pc_src,
  output logic                    illegal,
  output logic [COUNT_WIDTH-1:0]  retired
);

  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);

  state_e state, state_next;
  class_e cls_dec, cls_q;

  opcode_classifier u_classifier (
    .opcode (opcode),
    .cls    (cls_dec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_FETCH;
      cls_q <= CLS_INVALID;
    end else begin
      state <= state_next;
      if (state == ST_DECODE) cls_q <= cls_dec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)           retired <= '0;
    else if (pc_write) retired <= retired + COUNT_ONE;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_FETCH:  if (imem_ready) state_next = ST_DECODE;
      ST_DECODE: state_next = (cls_dec == CLS_INVALID) ? ST_FETCH : ST_EXECUTE;
      ST_EXECUTE: begin
        case (cls_q)
          CLS_LOAD, CLS_STORE: state_next = ST_MEMORY;
          CLS_RTYPE:           state_next = ST_WRITEBACK;
          default:             state_next = ST_FETCH;
        endcase
      end
      ST_MEMORY: begin
        if (dmem_ready) state_next = (cls_q == CLS_LOAD) ? ST_WRITEBACK : ST_FETCH;
      end
      ST_WRITEBACK: state_next = ST_FETCH;
      default:      state_next = ST_FETCH;
    endcase
  end

  // Outputs are forced low during rst so an abandoned instruction never strobes.
  always_comb begin
    imem_req     = 1'b0;
    ir_write     = 1'b0;
    reg2_loc     = 1'b0;
    uncondbranch = 1'b0;
    branch       = 1'b0;
    mem_read     = 1'b0;
    mem_to_reg   = 1'b0;
    alu_op       = ALU_ADD;
    mem_write    = 1'b0;
    alu_src      = 1'b0;
    reg_write    = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 1'b0;
    illegal      = 1'b0;
    if (!rst) begin
      if (state inside {ST_EXECUTE, ST_MEMORY, ST_WRITEBACK}) begin
        case (cls_q)
          CLS_RTYPE: alu_op = ALU_FUNCT;
          CLS_LOAD: begin
            alu_src    = 1'b1;
            mem_to_reg = 1'b1;
          end
          CLS_STORE: begin
            reg2_loc = 1'b1;
            alu_src  = 1'b1;
          end
          CLS_CBZ: begin
            reg2_loc = 1'b1;
            branch   = 1'b1;
            alu_op   = ALU_PASS_B;
          end
          CLS_B:   uncondbranch = 1'b1;
          default: ;
        endcase
      end
      case (state)
        ST_FETCH: begin
          imem_req = 1'b1;
          ir_write = imem_ready;
        end
        ST_DECODE: illegal = (cls_dec == CLS_INVALID);
        ST_EXECUTE: begin
          if (cls_q == CLS_CBZ) begin
            pc_write = 1'b1;
            pc_src   = alu_zero;
          end else if (cls_q == CLS_B) begin
            pc_write = 1'b1;
            pc_src   = 1'b1;
          end
        end
        ST_MEMORY: begin
          mem_read  = (cls_q == CLS_LOAD);
          mem_write = (cls_q == CLS_STORE);
          pc_write  = (cls_q == CLS_STORE) && dmem_ready;
        end
        ST_WRITEBACK: begin
          reg_write = 1'b1;
          pc_write  = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: a driver issues instructions with
// random wait states, a monitor checks each completed instruction against an
// instruction-level reference model.
module tb_multicycle_control;

  localparam int CW = 4;
  localparam int C_R = 0, C_L = 1, C_S = 2, C_CBZ = 3, C_B = 4, C_INV = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [10:0]   opcode;
  logic          alu_zero, imem_ready, dmem_ready;
  logic          imem_req, ir_write, reg2_loc, uncondbranch, branch, mem_read;
  logic          mem_to_reg, mem_write, alu_src, reg_write, pc_write, pc_src, illegal;
  logic [1:0]    alu_op;
  logic [CW-1:0] retired;

  always #5 clk = ~clk;

  multicycle_control #(.OPCODE_WIDTH(11), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .alu_zero(alu_zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req),
    .ir_write(ir_write), .reg2_loc(reg2_loc), .uncondbranch(uncondbranch),
    .branch(branch), .mem_read(mem_read), .mem_to_reg(mem_to_reg), .alu_op(alu_op),
    .mem_write(mem_write), .alu_src(alu_src), .reg_write(reg_write),
    .pc_write(pc_write), .pc_src(pc_src), .illegal(illegal), .retired(retired)
  );

  typedef struct {
    int lat; int illegal; int pc_src; int alu_op;
    int reg2_loc; int uncond; int branch; int mem_to_reg; int alu_src;
    int n_rd; int n_wr; int n_rw; int n_pcw; int n_req; int ret_before;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;
  int model_retired = 0;

  task automatic chk(string name, int act, int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int outs();
    return int'({imem_req, ir_write, reg2_loc, uncondbranch, branch, mem_read,
                 mem_to_reg, alu_op, mem_write, alu_src, reg_write, pc_write,
                 pc_src, illegal});
  endfunction

  function automatic int ref_class(logic [10:0] op);
    logic [7:0] hi8;
    logic [5:0] hi6;
    hi8 = op[10:3];
    hi6 = op[10:5];
    if (op == 11'h458 || op == 11'h658 || op == 11'h450 || op == 11'h550) return C_R;
    if (op == 11'h7C2) return C_L;
    if (op == 11'h7C0) return C_S;
    if (hi8 == 8'hB4) return C_CBZ;
    if (hi6 == 6'h05) return C_B;
    return C_INV;
  endfunction

  // Reference model: expected per-instruction behaviour from the class table.
  task automatic issue(logic [10:0] op, int fw, int mw, bit az, int pre_req);
    exp_t e;
    int c;
    bit is_mem;
    c = ref_class(op);
    is_mem = (c == C_L || c == C_S);
    if (!is_mem) mw = 0;
    e = '{default: 0};
    e.n_req = fw + 1 + pre_req;
    e.ret_before = model_retired;
    case (c)
      C_R:   begin e.lat = 4; e.alu_op = 2; e.n_rw = 1; e.n_pcw = 1; end
      C_L:   begin e.lat = 5 + mw; e.alu_src = 1; e.mem_to_reg = 1; e.n_rd = 1 + mw;
                   e.n_rw = 1; e.n_pcw = 1; end
      C_S:   begin e.lat = 4 + mw; e.reg2_loc = 1; e.alu_src = 1; e.n_wr = 1 + mw;
                   e.n_pcw = 1; end
      C_CBZ: begin e.lat = 3; e.reg2_loc = 1; e.branch = 1; e.alu_op = 1;
                   e.pc_src = az; e.n_pcw = 1; end
      C_B:   begin e.lat = 3; e.uncond = 1; e.pc_src = 1; e.n_pcw = 1; end
      default: begin e.lat = 2; e.illegal = 1; end
    endcase
    if (c != C_INV) model_retired = (model_retired + 1) % (1 << CW);
    q.push_back(e);
    for (int k = 0; k < fw; k++) begin
      @(negedge clk);
      imem_ready = 1'b0;
      opcode = 11'($urandom);
      dmem_ready = 1'($urandom);
    end
    @(negedge clk);
    imem_ready = 1'b1;
    opcode = op;
    alu_zero = az;
    dmem_ready = 1'($urandom);
    for (int cy = 1; cy < e.lat; cy++) begin
      @(negedge clk);
      imem_ready = 1'($urandom);
      dmem_ready = is_mem ? (cy >= 3 + mw) : 1'($urandom);
    end
  endtask

  // Monitor: accumulate strobes per instruction, compare on completion.
  int cyc = 0, t0 = 0;
  int a_req = 0, a_rd = 0, a_wr = 0, a_rw = 0, a_pcw = 0, a_both = 0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst !== 1'b0) begin
        a_req = 0; a_rd = 0; a_wr = 0; a_rw = 0; a_pcw = 0; a_both = 0;
        continue;
      end
      cyc++;
      if (imem_req)  a_req++;
      if (mem_read)  a_rd++;
      if (mem_write) a_wr++;
      if (reg_write) a_rw++;
      if (pc_write)  a_pcw++;
      if (mem_read && mem_write) a_both++;
      if (ir_write) begin
        t0 = cyc;
        chk("fetch_outputs", outs(), (1 << 14) | (1 << 13));
      end
      if (pc_write || illegal) begin
        if (q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_completion: got pc_write=%0d illegal=%0d expected none",
                   pc_write, illegal);
        end else begin
          e = q.pop_front();
          chk("latency", cyc - t0 + 1, e.lat);
          chk("illegal", illegal, e.illegal);
          chk("pc_src", pc_src, e.pc_src);
          chk("alu_op", alu_op, e.alu_op);
          chk("reg2_loc", reg2_loc, e.reg2_loc);
          chk("uncondbranch", uncondbranch, e.uncond);
          chk("branch", branch, e.branch);
          chk("mem_to_reg", mem_to_reg, e.mem_to_reg);
          chk("alu_src", alu_src, e.alu_src);
          chk("retired", retired, e.ret_before);
          chk("mem_read_cycles", a_rd, e.n_rd);
          chk("mem_write_cycles", a_wr, e.n_wr);
          chk("reg_write_cycles", a_rw, e.n_rw);
          chk("pc_write_cycles", a_pcw, e.n_pcw);
          chk("imem_req_cycles", a_req, e.n_req);
          chk("rd_wr_overlap", a_both, 0);
        end
        a_req = 0; a_rd = 0; a_wr = 0; a_rw = 0; a_pcw = 0; a_both = 0;
      end
    end
  end

  initial begin
    logic [10:0] rops [4];
    logic [10:0] op;
    int c, guard;
    rops = '{11'h458, 11'h658, 11'h450, 11'h550};
    rst = 1'b1; opcode = '0; alu_zero = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      #2;
      chk("init_rst_outputs", outs(), 0);
      chk("init_rst_retired", retired, 0);
    end

    // Start a LOAD, stall it in MEMORY, then reset it away.
    @(negedge clk);
    rst = 1'b0; imem_ready = 1'b1; opcode = 11'h7C2; dmem_ready = 1'b0;
    @(negedge clk); imem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    chk("mid_load_mem_read", mem_read, 1);
    repeat (2) begin
      @(negedge clk);
      rst = 1'b1;
      #2;
      chk("mid_rst_outputs", outs(), 0);
    end
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("post_rst_outputs", outs(), 1 << 14);
    chk("post_rst_retired", retired, 0);

    issue(11'h458, 0, 0, 0, 1);
    issue(11'h7C2, 0, 2, 0, 0);
    issue(11'h7C0, 1, 1, 0, 0);
    issue(11'h5A7, 0, 0, 1, 0);
    issue(11'h5A0, 0, 0, 0, 0);
    issue(11'h0AF, 2, 0, 0, 0);
    issue(11'h765, 0, 0, 0, 0);
    issue(11'h550, 0, 0, 0, 0);

    for (int n = 0; n < 300; n++) begin
      c = $urandom_range(0, 5);
      case (c)
        C_R:   op = rops[$urandom_range(0, 3)];
        C_L:   op = 11'h7C2;
        C_S:   op = 11'h7C0;
        C_CBZ: op = {8'hB4, 3'($urandom)};
        C_B:   op = {6'h05, 5'($urandom)};
        default: begin
          op = 11'($urandom);
          while (ref_class(op) != C_INV) op = 11'($urandom);
        end
      endcase
      issue(op, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
            $urandom_range(0, 3), 1'($urandom), 0);
    end

    for (int n = 0; n < 17; n++) issue({6'h05, 5'($urandom)}, 0, 0, 0, 0);

    imem_ready = 1'b0;
    guard = 0;
    while (q.size() != 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_pending", q.size(), 0);
    repeat (2) @(negedge clk);
    #3;
    chk("final_retired", retired, model_retired);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
